// File: rtl/dca_mru_inst_queue.sv
// rtl/dca_mru_inst_queue.sv - MRU instruction queue feeding the DCA MRU controller
//
// Buffers full MRU instructions from the host side and presents the head
// entry to the MRU controller as a held-valid request. The controller's
// one-cycle completion pulse retires the head entry.
//
// Ports:
//   clk            clock
//   rstnn          asynchronous active-low reset
//   clear          synchronous clear of pointers, counters and flags
//   push_valid     host offers push_inst
//   push_inst      instruction to enqueue
//   push_ready     queue not full
//   mru_inst_valid head entry valid (controller request)
//   mru_inst       head entry
//   mru_inst_done  controller completion pulse, pops the head
//   count          current occupancy
//   done_count     wrapping count of retired instructions
//   drained        one-cycle pulse after a pop empties the queue
//   err_underflow  sticky: done seen while empty
//   err_overflow   sticky: push offered while full

`ifndef BW_DCA_MRU_INST
`define BW_DCA_MRU_INST 64
`endif

module dca_mru_inst_queue #(
  parameter int DEPTH       = 4,
  parameter int BW_INST     = `BW_DCA_MRU_INST,
  parameter int BW_DONE_CNT = 16
) (
  input  logic                     clk,
  input  logic                     rstnn,
  input  logic                     clear,
  input  logic                     push_valid,
  input  logic [BW_INST-1:0]       push_inst,
  output logic                     push_ready,
  output logic                     mru_inst_valid,
  output logic [BW_INST-1:0]       mru_inst,
  input  logic                     mru_inst_done,
  output logic [$clog2(DEPTH):0]   count,
  output logic [BW_DONE_CNT-1:0]   done_count,
  output logic                     drained,
  output logic                     err_underflow,
  output logic                     err_overflow
);

  localparam int PW = $clog2(DEPTH);

  typedef logic [PW:0] ptr_t;

  logic [BW_INST-1:0] mem [DEPTH];
  ptr_t               wptr;
  ptr_t               rptr;
  logic               empty;
  logic               full;
  logic               push;
  logic               pop;

  // MSB of each pointer is the wrap bit: equal low bits with differing
  // wrap bits means the writer is a full lap ahead of the reader.
  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign count = wptr - rptr;

  assign push = push_valid & ~full;
  assign pop  = mru_inst_done & ~empty;

  assign push_ready     = ~full;
  assign mru_inst_valid = ~empty;
  assign mru_inst       = mem[rptr[PW-1:0]];

  // Storage is not reset; stale contents are never visible because
  // mru_inst is only meaningful while mru_inst_valid is high.
  always_ff @(posedge clk) begin
    if (!clear && push) begin
      mem[wptr[PW-1:0]] <= push_inst;
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      wptr          <= '0;
      rptr          <= '0;
      done_count    <= '0;
      drained       <= 1'b0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else if (clear) begin
      wptr          <= '0;
      rptr          <= '0;
      done_count    <= '0;
      drained       <= 1'b0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + ptr_t'(1);
      end
      if (pop) begin
        rptr       <= rptr + ptr_t'(1);
        done_count <= done_count + BW_DONE_CNT'(1);
      end
      // A push in the same cycle refills the queue, so no drain event.
      drained <= pop & (count == ptr_t'(1)) & ~push;
      if (mru_inst_done && empty) begin
        err_underflow <= 1'b1;
      end
      if (push_valid && full) begin
        err_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/dca_mru_inst_queue.md
# dca_mru_inst_queue

Instruction queue directly upstream of the DCA matrix register unit (MRU) controller. It buffers full MRU instructions (opcode plus two aligned matrix-info fields) from the control-register/host side. It presents the head entry to the controller as a held-valid request and retires the entry on the controller's one-cycle completion pulse. It also provides occupancy, completion counting, an empty-on-drain pulse and sticky error flags for software.

## Interface
- DEPTH, 4, queue entries; power of two, minimum 2
- BW_INST, `BW_DCA_MRU_INST, width of one MRU instruction
- BW_DONE_CNT, 16, width of the wrapping completion counter
- clk  input  1  clock; single clock domain
- rstnn  input  1  reset, asynchronous, active-low
- clear  input  1  synchronous clear; empties the queue, zeroes the counters and flags
- push_valid  input  1  host offers an instruction
- push_inst  input  BW_INST  instruction to enqueue
- push_ready  output  1  queue not full
- mru_inst_valid  output  1  head entry valid; goes to the controller's request input
- mru_inst  output  BW_INST  head entry; stable while mru_inst_valid is 1 and no pop occurs
- mru_inst_done  input  1  controller completion pulse; pops the head entry
- count  output  clog2(DEPTH)+1  current occupancy
- done_count  output  BW_DONE_CNT  number of retired instructions, wraps modulo 2^BW_DONE_CNT
- drained  output  1  one-cycle pulse when a pop leaves the queue empty
- err_underflow  output  1  sticky; set when mru_inst_done arrives while the queue is empty
- err_overflow  output  1  sticky; set when push_valid is 1 while push_ready is 0

## Operation
- Storage is a register array of DEPTH×BW_INST with write pointer wptr and read pointer rptr, each clog2(DEPTH)+1 bits wide. The MSB is the wrap bit.
- Empty: wptr==rptr. Full: the low bits are equal and the wrap bits differ. count = wptr−rptr, modulo 2^(clog2(DEPTH)+1).
- push = push_valid & push_ready. On push, the array at wptr[low] takes push_inst and wptr increments.
- pop = mru_inst_done & ~empty. On pop, rptr increments and done_count increments.
- push_ready = ~full. A push is refused when the queue is full, even if a pop occurs in the same cycle; there is no bypass.
- Push and pop in the same cycle, with the queue neither full nor empty: both happen and count is unchanged.
- Push while empty: the entry becomes visible at mru_inst on the next cycle. There is no same-cycle passthrough.
- mru_inst = array[rptr[low]]. mru_inst_valid = ~empty.
- The head is never altered by a push; the controller may sample it over many cycles.
- drained = pop & (count==1) & ~push, registered so it appears the cycle after the pop.
- mru_inst_done while empty: it is ignored for the pointers and done_count, and err_underflow is set. This applies even if a push happens in the same cycle.
- err_overflow is set by push_valid & full.
- Both error flags clear only on reset or clear.
- clear has priority over push and pop in the same cycle. It resets the pointers, count, done_count, drained and both flags. Array contents are left unchanged.

## Timing
- Reset values: push_ready=1, mru_inst_valid=0, count=0, done_count=0, drained=0, err_underflow=0, err_overflow=0. mru_inst is don't-care while mru_inst_valid=0.
- Latency is 1 cycle from push acceptance to mru_inst_valid, when the queue was empty.
- Retire latency: count, done_count and the next head all update on the clock edge that samples mru_inst_done.
- Reset asserted mid-operation: everything returns to reset values asynchronously. An instruction the controller already latched is not tracked.
- done_count wraps from 2^BW_DONE_CNT−1 to 0 with no flag.
- All outputs are registered or derived from registered pointers. There is no combinational path from push_valid or mru_inst_done to any output.

## Test plan
- Reset, then push A, B, C on consecutive cycles with no done -> count 1,2,3. mru_inst=A from the cycle after A's push. push_ready stays 1.
- DEPTH=4: push 4 entries -> push_ready=0. A 5th push_valid is not stored, and err_overflow=1 on the next cycle. Then pulse done -> head advances to the 2nd entry, count=3, push_ready=1.
- At count=2, push and done in the same cycle -> count remains 2, head advances, the new entry is appended at the tail, done_count+1.
- Queue with 1 entry, done pulse -> count=0, mru_inst_valid=0, drained=1 for exactly one cycle. A second done pulse -> err_underflow=1 and done_count unchanged.
- Push 3 entries, then assert clear together with push_valid and done -> count=0, done_count=0, flags 0. The simultaneous push and pop are discarded.
- BW_DONE_CNT=4: retire 17 instructions through repeated push/done -> done_count=1. Order matches push order for all 17, including across pointer wrap.
